memory_stage: RTL and testbench

//  MEM pipeline stage of the 8-bit core, between execute and writeback_stage.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/data_ram.sv | 28 ++
 rtl/memory_stage.sv | 156 +++++++++++++++
 tb/tb_memory_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit core pipeline (execute / memory / writeback).
package cpu_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned PERF_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Operation fields latched while a memory access is in flight
    typedef struct packed {
        logic                  is_store;
        logic                  is_load;
        logic                  result_src;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     write_data;
    } mem_op_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM; read data only updates on a read enable.
module data_ram
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data RAM access with wait states, stall to execute, WB registers.
// Optional load/store performance counters when MEM_PERF_CNT_EN is defined.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  ResultSrc_in,
    input  logic                  RegWrite_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     write_data,
    output logic                  stall,
    output logic                  out_valid,
    output logic                  ResultSrc,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     mem_data
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     load_cnt,
    output logic [PERF_W-1:0]     store_cnt
`endif
);

    localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    mem_op_t           op_q;
    mem_op_t           in_op;
    mem_op_t           cur_op;
    logic              load_flag;
    logic              mem_op;
    logic              accept;
    logic              complete;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] rdata;

    // Current operation: live inputs while idle, latched copy while busy
    always_comb begin
        in_op            = '0;
        in_op.is_store   = MemWrite;
        in_op.is_load    = MemRead & ~MemWrite;
        in_op.result_src = ResultSrc_in;
        in_op.reg_write  = RegWrite_in;
        in_op.rd         = rd_in;
        in_op.alu_result = alu_result_in;
        in_op.write_data = write_data;

        mem_op   = MemRead | MemWrite;
        cur_op   = (state == IDLE) ? in_op : op_q;
        accept   = (state == IDLE) && in_valid && !flush;
        complete = ((state == BUSY) && !flush && (cnt == '0))
                || (accept && mem_op && (WAIT_STATES == 0));
        ram_we   = complete & cur_op.is_store;
        ram_re   = complete & cur_op.is_load;
    end

    data_ram #(
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_op.alu_result[ADDR_W-1:0]),
        .wdata (cur_op.write_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            out_valid  <= 1'b0;
            ResultSrc  <= 1'b0;
            RegWrite   <= 1'b0;
            rd         <= '0;
            alu_result <= '0;
            load_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            RegWrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        ResultSrc  <= 1'b0;
                        rd         <= '0;
                        alu_result <= '0;
                        load_flag  <= 1'b0;
                    end else if (in_valid && !mem_op) begin
                        out_valid  <= 1'b1;
                        ResultSrc  <= ResultSrc_in;
                        RegWrite   <= RegWrite_in;
                        rd         <= rd_in;
                        alu_result <= alu_result_in;
                        load_flag  <= 1'b0;
                    end else if (in_valid && (WAIT_STATES != 0)) begin
                        op_q  <= in_op;
                        cnt   <= CNT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush || (cnt == '0)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Memory access completion; stores never write back to the register file
            if (complete) begin
                out_valid  <= 1'b1;
                ResultSrc  <= cur_op.result_src;
                RegWrite   <= cur_op.reg_write & cur_op.is_load;
                rd         <= cur_op.rd;
                alu_result <= cur_op.alu_result;
                load_flag  <= cur_op.is_load;
            end
        end
    end

    assign stall    = (state == BUSY);
    assign mem_data = load_flag ? rdata : '0;

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (ram_re) begin
                load_cnt <= sat_inc(load_cnt);
            end
            if (ram_we) begin
                store_cnt <= sat_inc(store_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: WAIT_STATES=1 instance (a) and WAIT_STATES=3 instance (b).
module tb_memory_stage;
    import cpu_pkg::*;

    typedef logic [20:0] exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       flush = 1'b0;
    logic       MemRead = 1'b0;
    logic       MemWrite = 1'b0;
    logic       ResultSrc_in = 1'b0;
    logic       RegWrite_in = 1'b0;
    logic [2:0] rd_in = '0;
    logic [7:0] alu_result_in = '0;
    logic [7:0] write_data = '0;

    logic       stall_a, out_valid_a, ResultSrc_a, RegWrite_a;
    logic [2:0] rd_a;
    logic [7:0] alu_a, mem_data_a;
    logic       stall_b, out_valid_b, ResultSrc_b, RegWrite_b;
    logic [2:0] rd_b;
    logic [7:0] alu_b, mem_data_b;
`ifdef MEM_PERF_CNT_EN
    logic [15:0] load_cnt_a, store_cnt_a, load_cnt_b, store_cnt_b;
`endif

    int   checks = 0;
    int   errors = 0;
    int   b_done = 0;
    int   stall_cycles_b = 0;
    logic count_en = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] model_a [256];
    logic [7:0] model_b [256];

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(8), .WAIT_STATES(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .ResultSrc_in(ResultSrc_in),
        .RegWrite_in(RegWrite_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
        .write_data(write_data), .stall(stall_a), .out_valid(out_valid_a),
        .ResultSrc(ResultSrc_a), .RegWrite(RegWrite_a), .rd(rd_a),
        .alu_result(alu_a), .mem_data(mem_data_a)
`ifdef MEM_PERF_CNT_EN
        , .load_cnt(load_cnt_a), .store_cnt(store_cnt_a)
`endif
    );

    memory_stage #(.ADDR_W(8), .WAIT_STATES(3)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .ResultSrc_in(ResultSrc_in),
        .RegWrite_in(RegWrite_in), .rd_in(rd_in), .alu_result_in(alu_result_in),
        .write_data(write_data), .stall(stall_b), .out_valid(out_valid_b),
        .ResultSrc(ResultSrc_b), .RegWrite(RegWrite_b), .rd(rd_b),
        .alu_result(alu_b), .mem_data(mem_data_b)
`ifdef MEM_PERF_CNT_EN
        , .load_cnt(load_cnt_b), .store_cnt(store_cnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every completed op must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && out_valid_a === 1'b1) begin
            checks++;
            assert (qa.size() != 0) else begin
                errors++;
                $error("FAIL sb_a_extra observed=out_valid expected=no_output");
            end
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("sb_a", 32'({ResultSrc_a, RegWrite_a, rd_a, alu_a, mem_data_a}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (count_en) stall_cycles_b += int'(stall_b);
        if (reset === 1'b1 && out_valid_b === 1'b1) begin
            b_done++;
            checks++;
            assert (qb.size() != 0) else begin
                errors++;
                $error("FAIL sb_b_extra observed=out_valid expected=no_output");
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("sb_b", 32'({ResultSrc_b, RegWrite_b, rd_b, alu_b, mem_data_b}), 32'(e));
            end
        end
    end

    task automatic drive(input logic mr, input logic mw, input logic rs, input logic rw,
                         input logic [2:0] r, input logic [7:0] a, input logic [7:0] wd);
        MemRead = mr; MemWrite = mw; ResultSrc_in = rs; RegWrite_in = rw;
        rd_in = r; alu_result_in = a; write_data = wd;
    endtask

    function automatic exp_t expect_of(input logic mr, input logic mw, input logic rs,
                                       input logic rw, input logic [2:0] r,
                                       input logic [7:0] a, input logic [7:0] md);
        logic ew;
        ew = mw ? 1'b0 : rw;
        return {rs, ew, r, a, (mr & ~mw) ? md : 8'h00};
    endfunction

    // Instance a: one op from a negedge, checks latency of WAIT_STATES=1
    task automatic op_a(input logic mr, input logic mw, input logic rs, input logic rw,
                        input logic [2:0] r, input logic [7:0] a, input logic [7:0] wd);
        qa.push_back(expect_of(mr, mw, rs, rw, r, a, model_a[a]));
        if (mw) model_a[a] = wd;
        drive(mr, mw, rs, rw, r, a, wd);
        in_valid_a = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_a = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        if (mr | mw) begin
            chk("busy_stall", 32'(stall_a), 32'd1);
            chk("busy_no_valid", 32'(out_valid_a), 32'd0);
            @(posedge clk); @(negedge clk);
            chk("mem_done_valid", 32'(out_valid_a), 32'd1);
            chk("mem_done_stall", 32'(stall_a), 32'd0);
        end else begin
            chk("pass_no_stall", 32'(stall_a), 32'd0);
        end
    endtask

    // Instance a: memory op accepted then flushed while busy
    task automatic flushed_op_a(input logic mr, input logic mw, input logic [7:0] a,
                                input logic [7:0] wd);
        drive(mr, mw, 1'b1, 1'b1, 3'd4, a, wd);
        in_valid_a = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_a = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        chk("flush_busy_stall", 32'(stall_a), 32'd1);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_valid", 32'(out_valid_a), 32'd0);
        chk("flush_busy_regwrite", 32'(RegWrite_a), 32'd0);
        chk("flush_busy_idle", 32'(stall_a), 32'd0);
    endtask

    // Instance b: execute presents the op and holds it while the stage stalls
    task automatic op_b(input logic mr, input logic mw, input logic [2:0] r,
                        input logic [7:0] a, input logic [7:0] wd);
        int guard;
        qb.push_back(expect_of(mr, mw, 1'b1, 1'b1, r, a, model_b[a]));
        if (mw) model_b[a] = wd;
        drive(mr, mw, 1'b1, 1'b1, r, a, wd);
        in_valid_b = 1'b1;
        guard = 0;
        while (stall_b === 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (guard < 20) else begin
            errors++;
            $error("FAIL b_hold_timeout observed=%0d expected=<20", guard);
        end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_a", 32'({stall_a, out_valid_a, ResultSrc_a, RegWrite_a, rd_a, alu_a, mem_data_a}), 32'd0);
        chk("reset_b", 32'({stall_b, out_valid_b, ResultSrc_b, RegWrite_b, rd_b, alu_b, mem_data_b}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Passthrough, then idle cycle holds data with RegWrite/out_valid low
        op_a(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h3C, 8'h00);
        @(negedge clk);
        chk("idle_hold", 32'({out_valid_a, RegWrite_a, rd_a, alu_a}), 32'({1'b0, 1'b0, 3'd5, 8'h3C}));

        // Store then load back; store has RegWrite_in set to prove it is forced low
        op_a(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h10, 8'hA5);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h10, 8'h00);
        op_a(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h11, 8'h5A);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'h11, 8'h00);

        // Flushed store must not write
        op_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 8'h00);
        flushed_op_a(1'b0, 1'b1, 8'h20, 8'hFF);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h20, 8'h00);

        // Flush in idle: op not accepted, outputs cleared
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 8'h77, 8'h00);
        in_valid_a = 1'b1; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_a = 1'b0; flush = 1'b0;
        chk("flush_idle", 32'({out_valid_a, ResultSrc_a, RegWrite_a, rd_a, alu_a, mem_data_a}), 32'd0);

        // Reset while busy clears everything asynchronously
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h10, 8'h00);
        in_valid_a = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_a = 1'b0; MemRead = 1'b0;
        chk("pre_reset_busy", 32'(stall_a), 32'd1);
        reset = 1'b0;
        #1;
        chk("reset_mid_busy", 32'({stall_a, out_valid_a, ResultSrc_a, RegWrite_a, rd_a, alu_a, mem_data_a}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h10, 8'h00);

        // WAIT_STATES=3, back-to-back ops held by execute
        count_en = 1'b1;
        op_b(1'b0, 1'b1, 3'd1, 8'h40, 8'h11);
        op_b(1'b0, 1'b1, 3'd2, 8'h41, 8'h22);
        op_b(1'b1, 1'b0, 3'd3, 8'h40, 8'h00);
        op_b(1'b1, 1'b0, 3'd4, 8'h41, 8'h00);
        op_b(1'b1, 1'b0, 3'd5, 8'h40, 8'h00);
        in_valid_b = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        for (int i = 0; i < 30 && (qb.size() != 0 || stall_b === 1'b1); i++) @(negedge clk);
        @(negedge clk);
        count_en = 1'b0;
        chk("b_stall_cycles", 32'(stall_cycles_b), 32'd15);
        chk("b_completed", 32'(b_done), 32'd5);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

`ifdef MEM_PERF_CNT_EN
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h30, 8'h01);
        op_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h31, 8'h02);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h30, 8'h00);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h31, 8'h00);
        op_a(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'h10, 8'h00);
        flushed_op_a(1'b1, 1'b0, 8'h30, 8'h00);
        chk("perf_store_cnt", 32'(store_cnt_a), 32'd2);
        chk("perf_load_cnt", 32'(load_cnt_a), 32'd3);
`endif

        repeat (2) @(negedge clk);
        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
